// File: rtl/rom_download_packer.sv
// rom_download_packer: turns the hps_io byte download stream into 16-bit
// little-endian SDRAM word writes, throttles the HPS through ioctl_wait,
// captures DIP-switch bytes and flags ROM-load completion.
module rom_download_packer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_W     = 24,
  parameter logic [15:0] ROM_INDEX  = 16'd0,
  parameter logic [15:0] DIP_INDEX  = 16'd254
) (
  input  logic              i_EMU_MCLK,
  input  logic              i_EMU_INITRST,
  input  logic [15:0]       ioctl_index,
  input  logic              ioctl_download,
  input  logic [26:0]       ioctl_addr,
  input  logic [7:0]        ioctl_data,
  input  logic              ioctl_wr,
  output logic              ioctl_wait,
  output logic              o_WR_REQ,
  output logic [ADDR_W-1:0] o_WR_ADDR,
  output logic [15:0]       o_WR_DATA,
  output logic [1:0]        o_WR_BE,
  input  logic              i_WR_ACK,
  output logic [23:0]       o_DIPSW,
  output logic              o_ROM_READY,
  output logic              o_DL_DONE,
  output logic              o_OVERFLOW
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ENT_W = ADDR_W + 18;
  localparam int unsigned HI_SH = ADDR_W + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_FLUSH = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic              armed_q, armed_d;
  logic              dl_q;
  logic              pend_valid_q, pend_valid_d;
  logic [ADDR_W-1:0] pend_wa_q, pend_wa_d;
  logic [7:0]        pend_byte_q, pend_byte_d;
  logic              hold_valid_q, hold_valid_d;
  logic [ADDR_W-1:0] hold_wa_q, hold_wa_d;
  logic [7:0]        hold_byte_q, hold_byte_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [ENT_W-1:0]  mem_q [FIFO_DEPTH];
  logic              wait_q, wait_d;
  logic [23:0]       dip_q, dip_d;
  logic              rom_ready_q, rom_ready_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;

  logic              push_c;
  logic [ENT_W-1:0]  push_ent_c;
  logic              pop_c;
  logic              full_c;
  logic              dl_rise_c, dl_fall_c;
  logic              rom_wr_c, oob_c, odd_c;
  logic [ADDR_W-1:0] wa_c;

  // Next-state, queue push selection, DIP capture and throttle computation
  always_comb begin
    state_d      = state_q;
    armed_d      = armed_q | ~ioctl_download;
    pend_valid_d = pend_valid_q;
    pend_wa_d    = pend_wa_q;
    pend_byte_d  = pend_byte_q;
    hold_valid_d = hold_valid_q;
    hold_wa_d    = hold_wa_q;
    hold_byte_d  = hold_byte_q;
    dip_d        = dip_q;
    rom_ready_d  = rom_ready_q;
    done_d       = 1'b0;
    ovf_d        = ovf_q;
    push_c       = 1'b0;
    push_ent_c   = '0;

    dl_rise_c = ioctl_download & ~dl_q;
    dl_fall_c = ~ioctl_download & dl_q;
    rom_wr_c  = ioctl_wr && (ioctl_index == ROM_INDEX);
    oob_c     = (ioctl_addr >> HI_SH) != 27'd0;
    odd_c     = ioctl_addr[0];
    wa_c      = ioctl_addr[ADDR_W:1];
    full_c    = (count_q == CNT_W'(FIFO_DEPTH));
    pop_c     = i_WR_ACK && (count_q != '0);

    case (state_q)
      S_IDLE: begin
        if (dl_rise_c && armed_q && (ioctl_index == ROM_INDEX)) begin
          state_d     = S_LOAD;
          rom_ready_d = 1'b0;
          ovf_d       = 1'b0;
        end
      end
      S_LOAD: begin
        if (hold_valid_q) begin
          // Deferred odd byte goes out before anything new is accepted
          if (!full_c) begin
            push_c       = 1'b1;
            push_ent_c   = {hold_wa_q, hold_byte_q, 8'h00, 2'b10};
            hold_valid_d = 1'b0;
          end
        end else if (rom_wr_c) begin
          if (oob_c) begin
            ovf_d = 1'b1;
          end else if (!odd_c) begin
            if (pend_valid_q) begin
              push_c     = 1'b1;
              push_ent_c = {pend_wa_q, 8'h00, pend_byte_q, 2'b01};
            end
            pend_valid_d = 1'b1;
            pend_wa_d    = wa_c;
            pend_byte_d  = ioctl_data;
          end else if (pend_valid_q && (pend_wa_q == wa_c)) begin
            push_c       = 1'b1;
            push_ent_c   = {wa_c, ioctl_data, pend_byte_q, 2'b11};
            pend_valid_d = 1'b0;
          end else if (pend_valid_q) begin
            push_c       = 1'b1;
            push_ent_c   = {pend_wa_q, 8'h00, pend_byte_q, 2'b01};
            pend_valid_d = 1'b0;
            hold_valid_d = 1'b1;
            hold_wa_d    = wa_c;
            hold_byte_d  = ioctl_data;
          end else begin
            push_c     = 1'b1;
            push_ent_c = {wa_c, ioctl_data, 8'h00, 2'b10};
          end
        end
        if (dl_fall_c) begin
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (!full_c) begin
          if (hold_valid_q) begin
            push_c       = 1'b1;
            push_ent_c   = {hold_wa_q, hold_byte_q, 8'h00, 2'b10};
            hold_valid_d = 1'b0;
            if (!pend_valid_q) begin
              state_d = S_DRAIN;
            end
          end else if (pend_valid_q) begin
            push_c       = 1'b1;
            push_ent_c   = {pend_wa_q, 8'h00, pend_byte_q, 2'b01};
            pend_valid_d = 1'b0;
            state_d      = S_DRAIN;
          end else begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if ((count_q == '0) && !hold_valid_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_d      = 1'b1;
        rom_ready_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (ioctl_wr && (ioctl_index == DIP_INDEX) && (ioctl_addr < 27'd3)) begin
      case (ioctl_addr[1:0])
        2'd0:    dip_d[7:0]   = ioctl_data;
        2'd1:    dip_d[15:8]  = ioctl_data;
        default: dip_d[23:16] = ioctl_data;
      endcase
    end

    count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    // Throttle from next-cycle state so room for two pushes always remains
    wait_d  = (count_d >= CNT_W'(FIFO_DEPTH - 2)) | hold_valid_d | (state_d == S_FLUSH);
  end

  // Control, packing and output registers
  always_ff @(posedge i_EMU_MCLK) begin
    if (i_EMU_INITRST) begin
      state_q      <= S_IDLE;
      armed_q      <= 1'b0;
      dl_q         <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_wa_q    <= '0;
      pend_byte_q  <= '0;
      hold_valid_q <= 1'b0;
      hold_wa_q    <= '0;
      hold_byte_q  <= '0;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      wait_q       <= 1'b0;
      dip_q        <= '0;
      rom_ready_q  <= 1'b0;
      done_q       <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      armed_q      <= armed_d;
      dl_q         <= ioctl_download;
      pend_valid_q <= pend_valid_d;
      pend_wa_q    <= pend_wa_d;
      pend_byte_q  <= pend_byte_d;
      hold_valid_q <= hold_valid_d;
      hold_wa_q    <= hold_wa_d;
      hold_byte_q  <= hold_byte_d;
      count_q      <= count_d;
      wait_q       <= wait_d;
      dip_q        <= dip_d;
      rom_ready_q  <= rom_ready_d;
      done_q       <= done_d;
      ovf_q        <= ovf_d;
      if (push_c) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  // Word-write queue storage
  always_ff @(posedge i_EMU_MCLK) begin
    if (i_EMU_INITRST) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_c) begin
      mem_q[wr_ptr_q] <= push_ent_c;
    end
  end

  assign o_WR_REQ                         = (count_q != '0);
  assign {o_WR_ADDR, o_WR_DATA, o_WR_BE}  = mem_q[rd_ptr_q];
  assign ioctl_wait                       = wait_q;
  assign o_DIPSW                          = dip_q;
  assign o_ROM_READY                      = rom_ready_q;
  assign o_DL_DONE                        = done_q;
  assign o_OVERFLOW                       = ovf_q;

endmodule

// File: tb/tb_rom_download_packer.sv
// Directed bench for rom_download_packer: scoreboard of expected word writes
// checked as the SDRAM side pops them.
module tb_rom_download_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ioctl_index = 16'd0;
  logic        ioctl_download = 1'b0;
  logic [26:0] ioctl_addr = '0;
  logic [7:0]  ioctl_data = '0;
  logic        ioctl_wr = 1'b0;
  logic        ioctl_wait;
  logic        o_WR_REQ;
  logic [23:0] o_WR_ADDR;
  logic [15:0] o_WR_DATA;
  logic [1:0]  o_WR_BE;
  logic        i_WR_ACK = 1'b1;
  logic [23:0] o_DIPSW;
  logic        o_ROM_READY;
  logic        o_DL_DONE;
  logic        o_OVERFLOW;

  int checks = 0;
  int failures = 0;
  logic [41:0] sb[$];

  rom_download_packer dut (
    .i_EMU_MCLK    (clk),
    .i_EMU_INITRST (rst),
    .ioctl_index   (ioctl_index),
    .ioctl_download(ioctl_download),
    .ioctl_addr    (ioctl_addr),
    .ioctl_data    (ioctl_data),
    .ioctl_wr      (ioctl_wr),
    .ioctl_wait    (ioctl_wait),
    .o_WR_REQ      (o_WR_REQ),
    .o_WR_ADDR     (o_WR_ADDR),
    .o_WR_DATA     (o_WR_DATA),
    .o_WR_BE       (o_WR_BE),
    .i_WR_ACK      (i_WR_ACK),
    .o_DIPSW       (o_DIPSW),
    .o_ROM_READY   (o_ROM_READY),
    .o_DL_DONE     (o_DL_DONE),
    .o_OVERFLOW    (o_OVERFLOW)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [41:0] ent(input int a, input logic [15:0] d, input logic [1:0] be);
    return {24'(a), d, be};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: compare the head entry whenever the writer pops it
  always @(negedge clk) begin
    if (!rst && o_WR_REQ === 1'b1 && i_WR_ACK === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_entry", 64'(sb.size()), 64'd1);
      end else begin
        logic [41:0] e;
        e = sb.pop_front();
        check("entry", 64'({o_WR_ADDR, o_WR_DATA, o_WR_BE}), 64'(e));
      end
    end
  end

  task automatic wr_byte(input logic [26:0] a, input logic [7:0] d);
    int n = 0;
    while (ioctl_wait === 1'b1 && n < 300) begin
      step();
      n++;
    end
    if (n >= 300) begin
      check("wait_timeout", 64'(ioctl_wait), 64'd0);
    end else begin
      ioctl_addr = a;
      ioctl_data = d;
      ioctl_wr   = 1'b1;
      step();
      ioctl_wr   = 1'b0;
    end
  endtask

  task automatic start_dl(input logic [15:0] idx);
    ioctl_download = 1'b0;
    step();
    step();
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    step();
  endtask

  task automatic end_and_wait_done(input string tag);
    bit seen = 0;
    ioctl_download = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      step();
      if (o_DL_DONE === 1'b1) seen = 1;
    end
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    if (seen) begin
      check({tag, "_rom_ready"}, 64'(o_ROM_READY), 64'd1);
      step();
      check({tag, "_done_one_cycle"}, 64'(o_DL_DONE), 64'd0);
    end
    check({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    // Reset state
    step(); step(); step();
    rst = 1'b0;
    check("rst_req", 64'(o_WR_REQ), 64'd0);
    check("rst_wait", 64'(ioctl_wait), 64'd0);
    check("rst_dipsw", 64'(o_DIPSW), 64'd0);
    check("rst_ready", 64'(o_ROM_READY), 64'd0);
    check("rst_done", 64'(o_DL_DONE), 64'd0);
    check("rst_ovf", 64'(o_OVERFLOW), 64'd0);

    // Sequential even-length download, ACK held high
    sb.push_back(ent(0, 16'h1100, 2'b11));
    sb.push_back(ent(1, 16'h3322, 2'b11));
    start_dl(16'd0);
    wr_byte(27'd0, 8'h00);
    check("t1_no_req_on_even", 64'(o_WR_REQ), 64'd0);
    wr_byte(27'd1, 8'h11);
    check("t1_req_next_cycle", 64'(o_WR_REQ), 64'd1);
    wr_byte(27'd2, 8'h22);
    wr_byte(27'd3, 8'h33);
    end_and_wait_done("t1");

    // Odd total length, last byte flushed with low enable only
    sb.push_back(ent(0, 16'hBBAA, 2'b11));
    sb.push_back(ent(1, 16'h00CC, 2'b01));
    start_dl(16'd0);
    check("t2_ready_cleared", 64'(o_ROM_READY), 64'd0);
    wr_byte(27'd0, 8'hAA);
    wr_byte(27'd1, 8'hBB);
    wr_byte(27'd2, 8'hCC);
    end_and_wait_done("t2");

    // Non-sequential bytes split across two word writes via the hold register
    sb.push_back(ent(2, 16'h0055, 2'b01));
    sb.push_back(ent(4, 16'h6600, 2'b10));
    start_dl(16'd0);
    wr_byte(27'd4, 8'h55);
    wr_byte(27'd9, 8'h66);
    check("t3_wait_high", 64'(ioctl_wait), 64'd1);
    step();
    check("t3_wait_low", 64'(ioctl_wait), 64'd0);
    end_and_wait_done("t3");

    // Out-of-range byte is dropped and flagged
    sb.push_back(ent(0, 16'h2211, 2'b11));
    start_dl(16'd0);
    wr_byte(27'h2000000, 8'h77);
    check("t4_ovf_set", 64'(o_OVERFLOW), 64'd1);
    check("t4_ovf_no_req", 64'(o_WR_REQ), 64'd0);
    wr_byte(27'd0, 8'h11);
    wr_byte(27'd1, 8'h22);
    end_and_wait_done("t4");
    check("t4_ovf_sticky", 64'(o_OVERFLOW), 64'd1);

    // Back-pressure: ACK low for 100 cycles, then release
    for (int i = 0; i < 4; i++) begin
      sb.push_back(ent(i, {8'(8'h11 + 2 * i), 8'(8'h10 + 2 * i)}, 2'b11));
    end
    i_WR_ACK = 1'b0;
    start_dl(16'd0);
    check("t5_ovf_cleared", 64'(o_OVERFLOW), 64'd0);
    for (int i = 0; i < 4; i++) begin
      wr_byte(27'(i), 8'(8'h10 + i));
    end
    for (int i = 0; i < 100; i++) step();
    check("t5_wait_high", 64'(ioctl_wait), 64'd1);
    check("t5_req_high", 64'(o_WR_REQ), 64'd1);
    check("t5_head_stable", 64'({o_WR_ADDR, o_WR_DATA, o_WR_BE}), 64'(ent(0, 16'h1110, 2'b11)));
    i_WR_ACK = 1'b1;
    for (int i = 4; i < 8; i++) begin
      wr_byte(27'(i), 8'(8'h10 + i));
    end
    end_and_wait_done("t5");

    // Reset in mid-download: remaining bytes ignored until download goes low
    start_dl(16'd0);
    wr_byte(27'd0, 8'h99);
    rst = 1'b1;
    step();
    rst = 1'b0;
    wr_byte(27'd2, 8'h98);
    wr_byte(27'd3, 8'h97);
    for (int i = 0; i < 5; i++) step();
    check("t6_no_req", 64'(o_WR_REQ), 64'd0);
    check("t6_ready_low", 64'(o_ROM_READY), 64'd0);
    sb.push_back(ent(0, 16'hBEEF, 2'b11));
    start_dl(16'd0);
    wr_byte(27'd0, 8'hEF);
    wr_byte(27'd1, 8'hBE);
    end_and_wait_done("t6");

    // DIP path
    start_dl(16'd254);
    wr_byte(27'd0, 8'h5A);
    wr_byte(27'd1, 8'hA5);
    wr_byte(27'd2, 8'h0F);
    wr_byte(27'd3, 8'hFF);
    step();
    check("t7_dipsw", 64'(o_DIPSW), 64'h0FA55A);
    check("t7_no_req", 64'(o_WR_REQ), 64'd0);
    check("t7_ready_kept", 64'(o_ROM_READY), 64'd1);
    ioctl_download = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("t7_no_done", 64'(o_DL_DONE), 64'd0);
    check("t7_sb_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
